// File: rtl/fpu_div_pkg.sv
// Shared types and constants for the FPU divide path.
// Used by fdiv_post_norm and its rounding helper.
package fpu_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_NORM,
    S_ROUND
  } state_t;

  localparam logic [1:0] SPC_NONE = 2'b00;
  localparam logic [1:0] SPC_ZERO = 2'b01;
  localparam logic [1:0] SPC_INF  = 2'b10;
  localparam logic [1:0] SPC_NAN  = 2'b11;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic int exp_max(input int eb);
    return (1 << eb) - 1;
  endfunction

endpackage

// File: rtl/fdiv_rne_round.sv
// Round-to-nearest-even of a normalized mantissa.
// Purely combinational; shared with the multiply post-stage.
module fdiv_rne_round #(
  parameter int MANT_BITS = 24,
  parameter int EW        = 10
) (
  input  logic [MANT_BITS-1:0] mant,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic [EW-1:0]        exp,
  output logic [MANT_BITS-1:0] mant_r,
  output logic [EW-1:0]        exp_r,
  output logic                 carry
);

  logic               inc;
  logic [MANT_BITS:0] sum;

  assign inc = guard & (sticky | mant[0]);
  assign sum = {1'b0, mant} + {{MANT_BITS{1'b0}}, inc};
  assign carry = sum[MANT_BITS];

  // all-ones mantissa rolls over to 1.000 at the next binade
  assign mant_r = carry ? {1'b1, {(MANT_BITS-1){1'b0}}}
                        : sum[MANT_BITS-1:0];
  assign exp_r = exp + {{(EW-1){1'b0}}, carry};

endmodule

// File: rtl/fdiv_post_norm.sv
// Divide post-stage: normalize, RNE round, pack IEEE result.
// Optional status flags output enabled by FDIV_STATUS_FLAGS_EN.
module fdiv_post_norm
  import fpu_div_pkg::*;
#(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 24,
  parameter int QW        = MANT_BITS + 2
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          start,
  input  logic                          sign_in,
  input  logic [EXP_BITS+1:0]           exp_in,
  input  logic [1:0]                    special_in,
  input  logic [QW-1:0]                 div_q,
  input  logic                          div_ready,
  output logic                          busy,
  output logic                          out_valid,
  output logic [EXP_BITS+MANT_BITS-1:0] result
`ifdef FDIV_STATUS_FLAGS_EN
  ,
  output logic [2:0]                    flags
`endif
);

  localparam int RW = EXP_BITS + MANT_BITS;
  localparam int EW = EXP_BITS + 2;
  localparam logic signed [EW-1:0] EXP_TOP =
    EW'(exp_max(EXP_BITS));

  state_t state, state_d;

  logic                 sign_q;
  logic signed [EW-1:0] exp_q;
  logic [1:0]           spc_q;
  logic                 byp_q;
  logic [QW-1:0]        q_q;
  logic [MANT_BITS-1:0] mant_q;
  logic                 guard_q;
  logic                 sticky_q;

  logic [MANT_BITS-1:0] mant_r;
  logic signed [EW-1:0] exp_r;
  logic                 rnd_carry;
  logic                 unused_rnd;
  logic [RW-1:0]        res_d;
  logic                 ovf;
  logic                 unf;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= S_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_d = (special_in != SPC_NONE) ? S_ROUND : S_ARM;
      end
      // ready may still be high from the previous divide here
      S_ARM:   state_d = S_WAIT;
      S_WAIT:  if (div_ready) state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  fdiv_rne_round #(
    .MANT_BITS (MANT_BITS),
    .EW        (EW)
  ) u_rnd (
    .mant   (mant_q),
    .guard  (guard_q),
    .sticky (sticky_q),
    .exp    (exp_q),
    .mant_r (mant_r),
    .exp_r  (exp_r),
    .carry  (rnd_carry)
  );

  assign unused_rnd = rnd_carry ^ mant_r[MANT_BITS-1];

  always_comb begin
    res_d = '0;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (byp_q) begin
      unique case (spc_q)
        SPC_ZERO: res_d = {sign_q, {(RW-1){1'b0}}};
        SPC_INF:  res_d = {sign_q, {EXP_BITS{1'b1}},
                           {(MANT_BITS-1){1'b0}}};
        default:  res_d = {1'b0, {EXP_BITS{1'b1}}, 1'b1,
                           {(MANT_BITS-2){1'b0}}};
      endcase
    end else if (exp_r >= EXP_TOP) begin
      ovf   = 1'b1;
      res_d = {sign_q, {EXP_BITS{1'b1}},
               {(MANT_BITS-1){1'b0}}};
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      unf   = 1'b1;
      res_d = {sign_q, {(RW-1){1'b0}}};
    end else begin
      res_d = {sign_q, exp_r[EXP_BITS-1:0],
               mant_r[MANT_BITS-2:0]};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      spc_q     <= SPC_NONE;
      byp_q     <= 1'b0;
      q_q       <= '0;
      mant_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            sign_q <= sign_in;
            exp_q  <= exp_in;
            spc_q  <= special_in;
            byp_q  <= (special_in != SPC_NONE);
            busy   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (div_ready) q_q <= div_q;
        end
        S_NORM: begin
          if (q_q[QW-1]) begin
            mant_q   <= q_q[QW-1:2];
            guard_q  <= q_q[1];
            sticky_q <= q_q[0];
          end else begin
            mant_q   <= q_q[QW-2:1];
            guard_q  <= q_q[0];
            sticky_q <= 1'b0;
            exp_q    <= exp_q - {{(EW-1){1'b0}}, 1'b1};
          end
        end
        S_ROUND: begin
          result    <= res_d;
          out_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef FDIV_STATUS_FLAGS_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      flags <= 3'b000;
    end else if (state == S_ROUND) begin
      if (byp_q)
        flags <= 3'b000;
      else
        flags <= {ovf, unf,
                  guard_q | sticky_q | ovf | unf};
    end
  end
`endif

endmodule

// File: tb/tb_fdiv_post_norm.sv
// Directed self-checking bench for fdiv_post_norm.
// Vectors carry hand-computed IEEE single results.
module tb_fdiv_post_norm;
  import fpu_div_pkg::*;

  logic        clk;
  logic        clrn;
  logic        start;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [1:0]  special_in;
  logic [25:0] div_q;
  logic        div_ready;
  logic        busy;
  logic        out_valid;
  logic [31:0] result;
`ifdef FDIV_STATUS_FLAGS_EN
  logic [2:0]  flags;
`endif

  int n_chk;
  int n_err;
  int n_vld;
  int n_done;

  fdiv_post_norm dut (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .sign_in    (sign_in),
    .exp_in     (exp_in),
    .special_in (special_in),
    .div_q      (div_q),
    .div_ready  (div_ready),
    .busy       (busy),
    .out_valid  (out_valid),
`ifdef FDIV_STATUS_FLAGS_EN
    .flags      (flags),
`endif
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) n_vld++;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic s,
                        input logic [9:0] e,
                        input logic [1:0] sp,
                        input logic [25:0] q,
                        input int dly,
                        input logic [31:0] want);
    @(negedge clk);
    start = 1'b1;
    sign_in = s;
    exp_in = e;
    special_in = sp;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_v0"}, 32'(out_valid), 32'd0);
    if (sp != SPC_NONE) begin
      div_ready = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
      div_ready = 1'b0;
      repeat (dly) @(negedge clk);
      div_q = q;
      div_ready = 1'b1;
      @(negedge clk);
      check({tag, "_vk0"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({tag, "_vk1"}, 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, result, want);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    n_done++;
    @(negedge clk);
    check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    check({tag, "_hold"}, result, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    n_vld = 0;
    n_done = 0;
    clrn = 1'b0;
    start = 1'b0;
    sign_in = 1'b0;
    exp_in = '0;
    special_in = SPC_NONE;
    div_q = '0;
    div_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_res", result, 32'd0);
    clrn = 1'b1;

    run_op("norm", 1'b0, 10'd127, SPC_NONE,
           26'h2000000, 10, 32'h3F800000);
    run_op("shift", 1'b0, 10'd128, SPC_NONE,
           26'h1000000, 3, 32'h3F800000);
    run_op("shift_neg", 1'b1, 10'd128, SPC_NONE,
           26'h1000000, 2, 32'hBF800000);
    run_op("tie_even", 1'b0, 10'd127, SPC_NONE,
           26'h2000002, 1, 32'h3F800000);
    run_op("tie_odd", 1'b0, 10'd127, SPC_NONE,
           26'h2000006, 1, 32'h3F800002);
    run_op("sticky_lo", 1'b0, 10'd127, SPC_NONE,
           26'h2000001, 0, 32'h3F800000);
    run_op("sticky_up", 1'b0, 10'd127, SPC_NONE,
           26'h2000003, 0, 32'h3F800001);
    run_op("carry", 1'b0, 10'd127, SPC_NONE,
           26'h3FFFFFE, 2, 32'h40000000);
    run_op("ovf", 1'b0, 10'd254, SPC_NONE,
           26'h3FFFFFE, 2, 32'h7F800000);
    run_op("unf", 1'b1, 10'd0, SPC_NONE,
           26'h2000000, 2, 32'h80000000);
    run_op("unf_shift", 1'b0, 10'd1, SPC_NONE,
           26'h1000000, 2, 32'h00000000);
    run_op("nan", 1'b1, 10'd127, SPC_NAN,
           26'h2000000, 0, QNAN);
    run_op("inf", 1'b1, 10'd127, SPC_INF,
           26'h2000000, 0, 32'hFF800000);
    run_op("zero", 1'b1, 10'd127, SPC_ZERO,
           26'h2000000, 0, 32'h80000000);

    // second start while busy must not relatch
    @(negedge clk);
    start = 1'b1;
    sign_in = 1'b0;
    exp_in = 10'd127;
    special_in = SPC_NONE;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    div_ready = 1'b0;
    start = 1'b1;
    sign_in = 1'b1;
    exp_in = 10'd5;
    special_in = SPC_NAN;
    @(negedge clk);
    start = 1'b0;
    check("busy_ign_busy", 32'(busy), 32'd1);
    check("busy_ign_v", 32'(out_valid), 32'd0);
    div_q = 26'h2000000;
    div_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_ign_vld", 32'(out_valid), 32'd1);
    check("busy_ign_res", result, 32'h3F800000);
    n_done++;
    @(negedge clk);

    // reset in WAIT aborts without a pulse
    start = 1'b1;
    sign_in = 1'b0;
    exp_in = 10'd127;
    special_in = SPC_NONE;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    div_ready = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b0;
    #1;
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_vld", 32'(out_valid), 32'd0);
    check("rstw_res", result, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
    div_q = 26'h2000006;
    div_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rstw_nopulse", 32'(n_vld), 32'(n_done));
    check("rstw_idle", 32'(busy), 32'd0);

    run_op("after_rst", 1'b1, 10'd127, SPC_NONE,
           26'h2000000, 4, 32'hBF800000);

    @(negedge clk);
    check("pulse_count", 32'(n_vld), 32'(n_done));

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fdiv_post_norm.md
Name: fdiv_post_norm

Overview:
- Downstream stage of the iterative mantissa divider in the FPU divide path.
- Latches sign, pre-computed exponent and special-case code when a divide starts.
- Waits for the divider's ready level, then normalizes and rounds the quotient (RNE) and packs an IEEE-754 result.
- Emits the result with a one-cycle valid pulse to the FPU result mux.

Parameters:
- EXP_BITS, 8, exponent field width.
- MANT_BITS, 24, mantissa width including the hidden bit.
- QW, MANT_BITS+2, quotient input width: 1 integer bit, then QW-1 fraction bits.

Ports:
- clk  in  1  clock.
- clrn  in  1  asynchronous active-low reset.
- start  in  1  divide launch, same cycle the divider sees start.
- sign_in  in  1  sign_a XOR sign_b.
- exp_in  in  EXP_BITS+2  signed biased exponent, ea-eb+bias.
- special_in  in  2  00 none, 01 zero, 10 inf, 11 NaN.
- div_q  in  QW  divider quotient, value in [0.5,2).
- div_ready  in  1  divider done, level signal.
- busy  out  1  operation in flight.
- out_valid  out  1  one-cycle pulse, result valid.
- result  out  EXP_BITS+MANT_BITS  packed {sign, exp, frac}.

Behaviour:
- Reset (clrn=0, async): state=IDLE, busy=0, out_valid=0, result=0, all internal registers 0. Reset mid-operation aborts silently; no out_valid follows.
- States: IDLE, ARM, WAIT, NORM, ROUND.
- IDLE, start=1:
  - Latch sign_in, exp_in, special_in; busy=1.
  - special_in!=00: go to ROUND with bypass flag set.
  - Otherwise go to ARM.
- ARM: one cycle; div_ready is ignored here (a stale ready from the previous op is still high). Go to WAIT.
- WAIT: stay until div_ready=1, then capture div_q and go to NORM.
- NORM, div_q[QW-1]=1:
  - mant=div_q[QW-1:2], guard=div_q[1], sticky=div_q[0], exp unchanged.
- NORM, div_q[QW-1]=0:
  - mant=div_q[QW-2:1], guard=div_q[0], sticky=0, exp=exp-1.
  - Go to ROUND.
- ROUND, round to nearest even: inc = guard & (sticky | mant[0]).
  - Add inc to mant. On carry-out, mant=1000..0 and exp+1.
- ROUND, after rounding:
  - exp >= 2^EXP_BITS-1: result=signed inf.
  - exp <= 0: result=signed zero (flush, no subnormals).
  - Otherwise pack {sign, exp[EXP_BITS-1:0], mant[MANT_BITS-2:0]}.
- ROUND, bypass: zero gives {sign,0}; inf gives {sign, all-ones exp, 0}; NaN gives the canonical qNaN 0x7FC00000 (sign 0).
- ROUND exit: register result, out_valid=1 for exactly one cycle, busy=0 on the same edge, go to IDLE.
- Latency: div_ready sampled high in WAIT at edge k; out_valid is high in the cycle after edge k+2. Special bypass: out_valid is high in the cycle after edge s+1, where s is the start edge.
- result holds until the next completion. out_valid=0 otherwise.
- start while busy=1 is ignored: no relatch, no state change.
- start in the same cycle as an out_valid pulse is accepted, because the FSM is already in IDLE.

Optional Feature:
- Macro: FDIV_STATUS_FLAGS_EN.
- When defined:
  - Adds output flags [2:0] = {overflow, underflow, inexact}, registered with result and valid while out_valid=1.
  - inexact = guard|sticky, or overflow/underflow occurred.
  - Flags are cleared on reset and on bypass results.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fpu_div_pkg holds:
  - state enum.
  - special-code constants SPC_NONE/ZERO/INF/NAN.
  - QNAN constant.
  - EXP_MAX localparam function.
- Sub-module fdiv_rne_round: combinational mant/guard/sticky/exp to rounded mant, exp and carry. Reusable by the multiply post-stage.

Test Plan:
- Normalized case: start, exp_in=127, sign 0, div_q=26'h2000000, div_ready after 10 cycles -> result 32'h3F800000, out_valid one cycle, 3 edges after ready.
- Shift case: exp_in=128, div_q=26'h1000000 (0.5) -> 32'h3F800000. With sign_in=1 -> 32'hBF800000.
- Rounding:
  - div_q=26'h2000002 (tie, even) -> 32'h3F800000.
  - div_q=26'h2000006 (tie, odd) -> 32'h3F800002.
  - div_q=26'h3FFFFFE with exp_in=127 (carry) -> 32'h40000000.
- Range:
  - exp_in=254 with div_q=26'h3FFFFFE -> 32'h7F800000.
  - exp_in=0 with div_q=26'h2000000 and sign 1 -> 32'h80000000.
- Specials: special_in=11 -> 32'h7FC00000 two edges after start, div_ready ignored. special_in=10, sign 1 -> 32'hFF800000.
- Control:
  - div_ready held high from the prior op at start -> no early completion.
  - Second start while busy -> ignored.
  - clrn pulsed in WAIT -> busy=0, no out_valid, next op correct.
